// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction-fetch front end.
//            c_xlen       - machine word width (32)
//            c_nop_instr  - default fill word for the instruction memory
//            fetch_entry_t - one prefetch-queue entry {pc, instr}
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          c_xlen      = 32;
    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

    typedef struct packed {
        logic [c_xlen-1:0] pc;
        logic [c_xlen-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_if
// Purpose  : Bus bundle between the fetch front end and its neighbours
//            (program loader, execute redirect, decode handshake).
//            slave  modport : fetch_unit side
//            master modport : loader / execute / decode side
//   prog_we, prog_addr, prog_data : program-load write port
//   imem_clr                      : fill instruction memory with NOP
//   redirect_en, redirect_pc      : flush and restart fetch at target
//   out_ready                     : decode accepts head entry
//   out_valid, out_pc, out_instr  : head entry of the prefetch queue
//   occupancy                     : entries currently held
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int QDEPTH     = 4
);
    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic                  prog_we;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [31:0]           prog_data;
    logic                  imem_clr;
    logic                  redirect_en;
    logic [31:0]           redirect_pc;
    logic                  out_ready;
    logic                  out_valid;
    logic [31:0]           out_pc;
    logic [31:0]           out_instr;
    logic [CNT_W-1:0]      occupancy;

    modport slave (
        input  prog_we, prog_addr, prog_data, imem_clr,
        input  redirect_en, redirect_pc, out_ready,
        output out_valid, out_pc, out_instr, occupancy
    );

    modport master (
        output prog_we, prog_addr, prog_data, imem_clr,
        output redirect_en, redirect_pc, out_ready,
        input  out_valid, out_pc, out_instr, occupancy
    );

endinterface : fetch_if
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Circular FIFO of fetch_entry_t. Flush has priority over push
//            and pop. Head entry is presented combinationally (zeros when
//            empty) so a push is visible right after its clock edge.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            i_flush           - discard all entries
//            i_push, i_push_data - enqueue (ignored when full without pop)
//            i_pop             - dequeue head (ignored when empty)
//            o_head            - head entry
//            o_full, o_empty, o_count - status
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_flush,
    input  wire logic         i_push,
    input  fetch_entry_t      i_push_data,
    input  wire logic         i_pop,
    output fetch_entry_t      o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    fetch_entry_t     r_store [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_head  = o_empty ? '0 : r_store[r_rd_ptr];

    // A full queue may still accept a push when the head leaves this cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointers are power-of-two wide, so wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; stale slots are never presented.
    always_ff @(posedge clk) begin
        if (w_do_push && !rst && !i_flush) begin
            r_store[r_wr_ptr] <= i_push_data;
        end
    end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch front end. Holds the PC and a word-addressed
//            instruction memory with a program-load port, and feeds decode
//            through a prefetch queue with a valid/ready handshake.
//            Priority: rst > redirect > load (prog_we/imem_clr) > fetch.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            bus (fetch_if.slave) - load port, redirect, decode handshake
//            stat_flush_cnt     - redirects seen (FETCH_STATS_EN only)
//            stat_stall_cnt     - cycles valid && !ready (FETCH_STATS_EN only)
// Config   : `define FETCH_STATS_EN adds the saturating statistic counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter int          QDEPTH     = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = c_nop_instr
) (
    input  wire logic   clk,
    input  wire logic   rst,
    fetch_if.slave      bus
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] stat_flush_cnt,
    output logic [15:0] stat_stall_cnt
`endif
);

    localparam int c_mem_words = 2 ** ADDR_WIDTH;
    localparam int c_cnt_w     = $clog2(QDEPTH + 1);

    logic [c_xlen-1:0]   r_pc;
    logic [31:0]         r_mem [c_mem_words];

    logic [31:0]         w_rd_instr;
    logic                w_pop;
    logic                w_push;
    logic                w_full;
    logic                w_empty;
    fetch_entry_t        w_push_entry;
    fetch_entry_t        w_head;
    logic [c_cnt_w-1:0]  w_count;
    logic                w_unused_ok;

    // Redirect targets are word aligned; the low bits are deliberately dropped.
    assign w_unused_ok = &{1'b1, bus.redirect_pc[1:0]};

    // ------------------------------------------------------------------
    // Instruction memory: async read, sync write, one-cycle bulk clear.
    // Not reset, so a program survives rst.
    // ------------------------------------------------------------------
    assign w_rd_instr = r_mem[r_pc[ADDR_WIDTH+1:2]];

    always_ff @(posedge clk) begin
        if (bus.imem_clr) begin
            for (int i = 0; i < c_mem_words; i++) begin
                r_mem[i] <= NOP_INSTR;
            end
        end else if (bus.prog_we) begin
            r_mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    // ------------------------------------------------------------------
    // Fetch control
    // ------------------------------------------------------------------
    assign w_pop  = bus.out_valid && bus.out_ready;
    assign w_push = !bus.redirect_en && !bus.prog_we && !bus.imem_clr &&
                    (!w_full || w_pop);

    assign w_push_entry.pc    = r_pc;
    assign w_push_entry.instr = w_rd_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (bus.redirect_en) begin
            r_pc <= {bus.redirect_pc[31:2], 2'b00};
        end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (bus.redirect_en),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign bus.out_valid = !w_empty;
    assign bus.out_pc    = w_head.pc;
    assign bus.out_instr = w_head.instr;
    assign bus.occupancy = w_count;

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef FETCH_STATS_EN
    logic [15:0] r_flush_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (bus.redirect_en && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
            if (bus.out_valid && !bus.out_ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign stat_flush_cnt = r_flush_cnt;
    assign stat_stall_cnt = r_stall_cnt;
`else
    // Statistics hardware is not built in this configuration.
`endif

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. Expected {pc, instr} pairs
//            are queued from a memory model when fetch is (re)started and
//            compared as decode consumes them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int AW = 8;
    localparam int QD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_if #(.ADDR_WIDTH(AW), .QDEPTH(QD)) bus ();

`ifdef FETCH_STATS_EN
    logic [15:0] stat_flush_cnt;
    logic [15:0] stat_stall_cnt;
`endif

    fetch_unit #(
        .ADDR_WIDTH (AW),
        .QDEPTH     (QD),
        .RESET_PC   (32'h0000_0000),
        .NOP_INSTR  (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus)
`ifdef FETCH_STATS_EN
        ,
        .stat_flush_cnt (stat_flush_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_mem [2**AW];
    logic [63:0] sb [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [AW-1:0] addr, input logic [31:0] data);
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        tick();
        bus.prog_we   = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2**AW; i++) model_mem[i] = 32'h0000_0013;
    endtask

    task automatic push_expect(input logic [31:0] start, input int n);
        logic [31:0] pc;
        for (int k = 0; k < n; k++) begin
            pc = start + 32'(4 * k);
            sb.push_back({pc, model_mem[pc[AW+1:2]]});
        end
    endtask

    task automatic test_reset();
        logic [63:0] want;
        rst = 1'b1;
        bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
        bus.imem_clr = 1'b0; bus.redirect_en = 1'b0; bus.redirect_pc = '0;
        bus.out_ready = 1'b0;
        tick(); tick();
        want = '0;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        vectors++;
        if ({bus.out_pc, bus.out_instr} !== want) begin miscompares++; $display("FAIL reset_head: got %h_%h want 0", bus.out_pc, bus.out_instr); end
        vectors++;
        if (bus.occupancy !== 3'd0) begin miscompares++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy); end
        rst = 1'b0;
        bus.imem_clr = 1'b1;
        tick();
        bus.imem_clr = 1'b0;
        model_clear();
        vectors++;
        if (bus.occupancy !== 3'd0) begin miscompares++; $display("FAIL clr_stall_occ: got %0d want 0", bus.occupancy); end
        tick();
        vectors++;
        if (bus.occupancy !== 3'd1 || bus.out_pc !== 32'h0) begin
            miscompares++; $display("FAIL first_fetch: got occ=%0d pc=%h want occ=1 pc=0", bus.occupancy, bus.out_pc);
        end
    endtask

    task automatic test_stream();
        logic [63:0] want;
        load_word(8'd0, 32'h0010_0093);
        load_word(8'd1, 32'h0020_0113);
        load_word(8'd2, 32'h0030_0193);
        load_word(8'd3, 32'h0040_0213);
        bus.out_ready = 1'b1;
        bus.redirect_en = 1'b1; bus.redirect_pc = 32'h0;
        tick();
        bus.redirect_en = 1'b0;
        sb.delete();
        push_expect(32'h0, 4);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0) begin
            miscompares++; $display("FAIL stream_flush: got valid=%b occ=%0d want 0/0", bus.out_valid, bus.occupancy);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            want = sb.pop_front();
            vectors++;
            if (bus.out_valid !== 1'b1 || {bus.out_pc, bus.out_instr} !== want) begin
                miscompares++;
                $display("FAIL stream_seq%0d: got v=%b pc=%h instr=%h want pc=%h instr=%h",
                         k, bus.out_valid, bus.out_pc, bus.out_instr, want[63:32], want[31:0]);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [63:0] want;
        int budget;
        bus.out_ready = 1'b0;
        bus.redirect_en = 1'b1; bus.redirect_pc = 32'h0;
        tick();
        bus.redirect_en = 1'b0;
        sb.delete();
        push_expect(32'h0, 6);
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++;
            if (bus.occupancy !== 3'((k < QD) ? k : QD)) begin
                miscompares++; $display("FAIL bp_occ%0d: got %0d want %0d", k, bus.occupancy, (k < QD) ? k : QD);
            end
        end
        bus.out_ready = 1'b1;
        budget = 0;
        while (sb.size() > 0 && budget < 40) begin
            if (bus.out_valid) begin
                want = sb.pop_front();
                vectors++;
                if ({bus.out_pc, bus.out_instr} !== want) begin
                    miscompares++;
                    $display("FAIL bp_stream: got pc=%h instr=%h want pc=%h instr=%h",
                             bus.out_pc, bus.out_instr, want[63:32], want[31:0]);
                end
            end
            tick();
            budget++;
        end
        if (sb.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL bp_timeout: %0d entries missing, want 0", sb.size());
            sb.delete();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_redirect_flush();
        logic [63:0] want;
        bus.out_ready = 1'b0;
        bus.redirect_en = 1'b1; bus.redirect_pc = 32'h0;
        tick();
        bus.redirect_en = 1'b0;
        tick(); tick(); tick();
        bus.out_ready = 1'b1;
        tick(); tick();
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_pc !== 32'h8 || bus.occupancy !== 3'd3) begin
            miscompares++; $display("FAIL rf_setup: got pc=%h occ=%0d want pc=8 occ=3", bus.out_pc, bus.occupancy);
        end
        bus.redirect_en = 1'b1; bus.redirect_pc = 32'h43;
        tick();
        bus.redirect_en = 1'b0;
        sb.delete();
        push_expect(32'h40, 1);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0 || bus.out_pc !== 32'h0) begin
            miscompares++; $display("FAIL rf_flush: got valid=%b occ=%0d pc=%h want 0/0/0", bus.out_valid, bus.occupancy, bus.out_pc);
        end
        tick();
        want = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || {bus.out_pc, bus.out_instr} !== want) begin
            miscompares++; $display("FAIL rf_target: got v=%b pc=%h instr=%h want pc=%h instr=%h",
                                    bus.out_valid, bus.out_pc, bus.out_instr, want[63:32], want[31:0]);
        end
    endtask

    task automatic test_redirect_with_load();
        logic [63:0] want;
        int budget;
        bus.out_ready = 1'b1;
        bus.prog_we = 1'b1; bus.prog_addr = 8'd5; bus.prog_data = 32'hDEAD_BEEF;
        bus.redirect_en = 1'b1; bus.redirect_pc = 32'h14;
        tick();
        bus.prog_we = 1'b0; bus.redirect_en = 1'b0;
        model_mem[5] = 32'hDEAD_BEEF;
        sb.delete();
        push_expect(32'h14, 3);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0) begin
            miscompares++; $display("FAIL rl_flush: got valid=%b occ=%0d want 0/0", bus.out_valid, bus.occupancy);
        end
        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            if (bus.out_valid) begin
                want = sb.pop_front();
                vectors++;
                if ({bus.out_pc, bus.out_instr} !== want) begin
                    miscompares++;
                    $display("FAIL rl_stream: got pc=%h instr=%h want pc=%h instr=%h",
                             bus.out_pc, bus.out_instr, want[63:32], want[31:0]);
                end
            end
            tick();
            budget++;
        end
        if (sb.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL rl_timeout: %0d entries missing, want 0", sb.size());
            sb.delete();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_imem_clr();
        logic [63:0] want;
        int budget;
        bus.out_ready = 1'b0;
        bus.imem_clr = 1'b1;
        bus.prog_we = 1'b1; bus.prog_addr = 8'd2; bus.prog_data = 32'h1234_5678;
        tick();
        bus.imem_clr = 1'b0; bus.prog_we = 1'b0;
        model_clear();
        bus.out_ready = 1'b1;
        bus.redirect_en = 1'b1; bus.redirect_pc = 32'h0;
        tick();
        bus.redirect_en = 1'b0;
        sb.delete();
        push_expect(32'h0, 6);
        budget = 0;
        while (sb.size() > 0 && budget < 30) begin
            if (bus.out_valid) begin
                want = sb.pop_front();
                vectors++;
                if ({bus.out_pc, bus.out_instr} !== want) begin
                    miscompares++;
                    $display("FAIL clr_stream: got pc=%h instr=%h want pc=%h instr=%h",
                             bus.out_pc, bus.out_instr, want[63:32], want[31:0]);
                end
            end
            tick();
            budget++;
        end
        if (sb.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL clr_timeout: %0d entries missing, want 0", sb.size());
            sb.delete();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        logic [63:0] want;
        int budget;
        for (int k = 0; k < 4; k++) load_word(8'(k), 32'hA000_0001 + 32'(k));
        bus.out_ready = 1'b1;
        bus.redirect_en = 1'b1; bus.redirect_pc = 32'h30;
        tick();
        bus.redirect_en = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0 || bus.out_pc !== 32'h0) begin
            miscompares++; $display("FAIL mid_reset: got valid=%b occ=%0d pc=%h want 0/0/0", bus.out_valid, bus.occupancy, bus.out_pc);
        end
        rst = 1'b0;
        sb.delete();
        push_expect(32'h0, 4);
        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            if (bus.out_valid) begin
                want = sb.pop_front();
                vectors++;
                if ({bus.out_pc, bus.out_instr} !== want) begin
                    miscompares++;
                    $display("FAIL mid_stream: got pc=%h instr=%h want pc=%h instr=%h",
                             bus.out_pc, bus.out_instr, want[63:32], want[31:0]);
                end
            end
            tick();
            budget++;
        end
        if (sb.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL mid_timeout: %0d entries missing, want 0", sb.size());
            sb.delete();
        end
        bus.out_ready = 1'b0;
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats();
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (stat_flush_cnt !== 16'd0 || stat_stall_cnt !== 16'd0) begin
            miscompares++; $display("FAIL stat_reset: got %0d/%0d want 0/0", stat_flush_cnt, stat_stall_cnt);
        end
        bus.redirect_en = 1'b1; bus.redirect_pc = 32'h0;
        tick(); tick(); tick();
        bus.redirect_en = 1'b0;
        vectors++;
        if (stat_flush_cnt !== 16'd3) begin
            miscompares++; $display("FAIL stat_flush: got %0d want 3", stat_flush_cnt);
        end
        tick();
        bus.out_ready = 1'b0;
        repeat (5) tick();
        bus.out_ready = 1'b1;
        vectors++;
        if (stat_stall_cnt !== 16'd5) begin
            miscompares++; $display("FAIL stat_stall: got %0d want 5", stat_stall_cnt);
        end
        bus.out_ready = 1'b0;
        repeat (65540) tick();
        vectors++;
        if (stat_stall_cnt !== 16'hFFFF) begin
            miscompares++; $display("FAIL stat_sat: got %h want FFFF", stat_stall_cnt);
        end
        tick();
        vectors++;
        if (stat_stall_cnt !== 16'hFFFF) begin
            miscompares++; $display("FAIL stat_sat_hold: got %h want FFFF", stat_stall_cnt);
        end
        bus.out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_with_load();
        test_imem_clr();
        test_reset_midstream();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the pipelined core. It holds the PC and a word-addressed instruction memory with a program-load port. A circular prefetch queue of configurable depth decouples fetch from decode. Decode consumes {pc, instr} through a valid/ready handshake; a redirect from execute (branch/jump) flushes the queue and restarts fetch at the target.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; memory holds 2**ADDR_WIDTH 32-bit words
QDEPTH, 4, prefetch queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, word written to every memory location by imem_clr

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
prog_we  in  1  program-load write strobe
prog_addr  in  ADDR_WIDTH  load word address
prog_data  in  32  load data
imem_clr  in  1  fill instruction memory with NOP_INSTR (independent of rst)
redirect_en  in  1  flush queue, restart fetch at redirect_pc
redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
out_ready  in  1  decode accepts head entry (low = hazard bubble)
out_valid  out  1  head entry valid
out_pc  out  32  PC of head entry
out_instr  out  32  instruction of head entry
occupancy  out  $clog2(QDEPTH+1)  queue entries held

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset: PC=RESET_PC, queue empty, out_valid=0, out_pc=0, out_instr=0, occupancy=0. Memory contents are retained.
- Memory: combinational read at PC[ADDR_WIDTH+1:2]. Write on clk edge when prog_we=1. imem_clr writes NOP_INSTR to all words in one cycle; if both are asserted, imem_clr wins.
- Pop: occurs when out_valid && out_ready. Head advances. Outputs show the new head, or zeros with out_valid=0 if the queue is now empty.
- Push condition: rst=0, redirect_en=0, prog_we=0, imem_clr=0, and (occupancy<QDEPTH or pop this cycle).
- Push action: enqueue {PC, mem[PC]} and set PC<=PC+4. Otherwise PC holds.
- Full with simultaneous pop: push and pop both happen; occupancy is unchanged.
- Latency: an entry pushed at edge N is visible at the outputs after edge N when the queue was empty. With out_ready=1 the steady throughput is one instruction per cycle.
- Redirect (priority rst > redirect > load > normal):
  - Queue cleared, out_valid=0, PC<={redirect_pc[31:2],2'b00}, no push that cycle.
  - A pop in the same cycle is discarded with the rest.
  - The target entry is valid after the following edge.
  - prog_we in the same cycle still writes memory.
- Load pause: while prog_we or imem_clr is high, fetch stalls. Pops continue, so decode can drain stale entries. The loader issues a redirect after loading.
- Wrap-around: queue pointers wrap modulo QDEPTH. The memory index wraps modulo 2**ADDR_WIDTH. PC wraps at 2**32.
- Reset mid-stream discards the queue; PC returns to RESET_PC.

Optional Feature:
FETCH_STATS_EN:
- With the macro defined, adds outputs stat_flush_cnt[15:0] and stat_stall_cnt[15:0].
  - stat_flush_cnt increments on each redirect_en.
  - stat_stall_cnt increments each cycle with out_valid && !out_ready.
  - Both counters saturate at 16'hFFFF and are cleared by rst.
- Without the macro, these ports and counters do not exist.

Decomposition:
- Package fetch_pkg holds NOP_INSTR default, the fetch_entry_t struct {pc[31:0], instr[31:0]} and the XLEN=32 constant.
- One natural sub-module: fetch_queue. It is a circular FIFO of fetch_entry_t with push, pop, flush, full, empty and count; flush has priority over push/pop.
- PC logic and memory stay in fetch_unit.

Test Plan:
- Load 00100093,00200113,00300193,00400213 at addr 0..3, redirect to 0, out_ready=1 -> out_pc 0,4,8,C with matching instrs on consecutive cycles, no gaps.
- QDEPTH=4, out_ready=0 -> occupancy climbs to 4 and holds; PC stalls at 0x10. Raise out_ready -> pcs 0,4,8,C,10,14 in order, no duplicate or drop.
- Queue holding pcs 8,C,10, redirect_en with redirect_pc=0x43 -> next cycle out_valid=0 and occupancy=0; following cycle out_pc=0x40.
- Redirect asserted with out_ready=1 and prog_we=1 (addr 5, data DEADBEEF) -> no entry survives, memory word 5 = DEADBEEF, fetch resumes at target.
- imem_clr pulse, then redirect to 0 -> every out_instr = 00000013. rst mid-stream -> out_valid=0, restart at RESET_PC, previously loaded words intact.
- FETCH_STATS_EN: 3 redirects plus 5 cycles of valid&&!ready -> stat_flush_cnt=3, stat_stall_cnt=5. Forcing the counter to FFFF -> it stays FFFF.
